// File: rtl/pulse_accumulator_ddr.sv
// Coherent pulse accumulator for a two-samples-per-clock ADC stream.
// Sums N triggered range gates into even/odd RAM banks, then streams them out in time order.
module pulse_accumulator_ddr #(
  parameter int DW       = 16,
  parameter int ACC_W    = 32,
  parameter int GATE_LEN = 256,
  parameter int NP_W     = 8,
  parameter int DLY_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic signed [DW-1:0]   x0_i,
  input  logic signed [DW-1:0]   x0z_i,
  input  logic                   trig_i,
  input  logic                   start_i,
  input  logic [NP_W-1:0]        n_pulses_i,
  input  logic [DLY_W-1:0]       delay_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   miss_o,
  output logic [ACC_W-1:0]       acc_data_o,
  output logic                   acc_valid_o,
  output logic                   acc_last_o,
  input  logic                   acc_ready_i
);
  localparam int AW = $clog2(GATE_LEN);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, ACCUM, READOUT} state_t;
  state_t state, state_nxt;

  logic              trig_q, edge_det;
  logic [NP_W-1:0]   n_lat, pulse_cnt;
  logic [DLY_W-1:0]  dly_lat, dly_cnt;
  logic [AW-1:0]     acc_addr, rd_addr, wr_addr_q;
  logic              gate_end, run_end;

  logic              wr_en_q, first_q;
  logic [DW-1:0]     x0_q, x0z_q;
  logic [ACC_W-1:0]  ram_even [GATE_LEN];
  logic [ACC_W-1:0]  ram_odd  [GATE_LEN];
  logic [ACC_W-1:0]  rd_even, rd_odd, sum_even, sum_odd;

  logic [AW:0]       iss_word;
  logic              iss_all, issue, rd_vld_q, rd_bank_q, rd_last_q;
  logic [ACC_W:0]    fifo [2];
  logic              wptr, rptr, pop, last_pop;
  logic [1:0]        fcount;

  assign edge_det = trig_i & ~trig_q;
  assign gate_end = (state == ACCUM) && (&acc_addr);
  assign run_end  = gate_end && ((pulse_cnt + NP_W'(1)) == n_lat);

  assign pop      = (fcount != 2'd0) && acc_ready_i;
  assign last_pop = pop && fifo[rptr][ACC_W];
  // Issue a read only if the word is guaranteed a skid slot when it lands.
  assign issue    = (state == READOUT) && !iss_all &&
                    (({1'b0, fcount} + {2'b0, rd_vld_q} - {2'b0, pop}) < 3'd2);

  assign busy_o      = (state != IDLE);
  assign acc_valid_o = (fcount != 2'd0);
  assign acc_data_o  = acc_valid_o ? fifo[rptr][ACC_W-1:0] : '0;
  assign acc_last_o  = acc_valid_o & fifo[rptr][ACC_W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i)  state_nxt = ARMED;
      ARMED:   if (edge_det) state_nxt = (dly_lat == '0) ? ACCUM : DELAY;
      DELAY:   if (dly_cnt == dly_lat) state_nxt = ACCUM;
      ACCUM:   if (gate_end) state_nxt = run_end ? READOUT : ARMED;
      READOUT: if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      trig_q    <= 1'b0;
      done_o    <= 1'b0;
      miss_o    <= 1'b0;
      n_lat     <= '0;
      dly_lat   <= '0;
      pulse_cnt <= '0;
      dly_cnt   <= '0;
      acc_addr  <= '0;
    end else begin
      state  <= state_nxt;
      trig_q <= trig_i;
      done_o <= (state == READOUT) && last_pop;
      if (state == IDLE && start_i) begin
        n_lat     <= (n_pulses_i == '0) ? NP_W'(1) : n_pulses_i;
        dly_lat   <= delay_i;
        pulse_cnt <= '0;
        miss_o    <= 1'b0;
      end else begin
        if (gate_end) pulse_cnt <= pulse_cnt + NP_W'(1);
        if (edge_det && (state == DELAY || state == ACCUM)) miss_o <= 1'b1;
      end
      if (state == ARMED)      dly_cnt <= DLY_W'(1);
      else if (state == DELAY) dly_cnt <= dly_cnt + DLY_W'(1);
      if (state == ACCUM) acc_addr <= acc_addr + AW'(1);
      else                acc_addr <= '0;
    end
  end

  // Read-modify-write: read at t, sum with 1-clock delayed samples and write at t+1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      first_q   <= 1'b0;
      x0_q      <= '0;
      x0z_q     <= '0;
    end else begin
      wr_en_q   <= (state == ACCUM);
      wr_addr_q <= acc_addr;
      first_q   <= (pulse_cnt == '0);
      x0_q      <= x0_i;
      x0z_q     <= x0z_i;
    end
  end

  assign sum_even = (first_q ? '0 : rd_even) + {{(ACC_W-DW){x0_q[DW-1]}}, x0_q};
  assign sum_odd  = (first_q ? '0 : rd_odd)  + {{(ACC_W-DW){x0z_q[DW-1]}}, x0z_q};
  assign rd_addr  = (state == READOUT) ? iss_word[AW:1] : acc_addr;

  always_ff @(posedge clk_i) begin
    rd_even <= ram_even[rd_addr];
    rd_odd  <= ram_odd[rd_addr];
    if (wr_en_q) begin
      ram_even[wr_addr_q] <= sum_even;
      ram_odd[wr_addr_q]  <= sum_odd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      iss_word  <= '0;
      iss_all   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_last_q <= 1'b0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      fcount    <= 2'd0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
    end else if (state != READOUT) begin
      iss_word <= '0;
      iss_all  <= 1'b0;
      rd_vld_q <= 1'b0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      fcount   <= 2'd0;
    end else begin
      rd_vld_q  <= issue;
      rd_bank_q <= iss_word[0];
      rd_last_q <= &iss_word;
      if (issue) begin
        iss_word <= iss_word + (AW+1)'(1);
        if (&iss_word) iss_all <= 1'b1;
      end
      if (rd_vld_q) begin
        fifo[wptr] <= {rd_last_q, (rd_bank_q ? rd_odd : rd_even)};
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      fcount <= fcount + {1'b0, rd_vld_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_pulse_accumulator_ddr.sv
// Directed bench for pulse_accumulator_ddr with GATE_LEN=8; a second ACC_W=17 instance checks wrap.
module tb_pulse_accumulator_ddr;
  localparam int GL = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [15:0] x0, x0z;
  logic trig, start, ready;
  logic [7:0]  n_pulses;
  logic [15:0] delay;
  logic busy, done, miss, valid, last;
  logic [31:0] data;
  logic busy17, done17, miss17, valid17, last17;
  logic [16:0] data17;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pulse_accumulator_ddr #(.DW(16), .ACC_W(32), .GATE_LEN(GL), .NP_W(8), .DLY_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .x0_i(x0), .x0z_i(x0z), .trig_i(trig), .start_i(start),
    .n_pulses_i(n_pulses), .delay_i(delay), .busy_o(busy), .done_o(done), .miss_o(miss),
    .acc_data_o(data), .acc_valid_o(valid), .acc_last_o(last), .acc_ready_i(ready));

  pulse_accumulator_ddr #(.DW(16), .ACC_W(17), .GATE_LEN(GL), .NP_W(8), .DLY_W(16)) dut17 (
    .clk_i(clk), .rst_i(rst_n), .x0_i(x0), .x0z_i(x0z), .trig_i(trig), .start_i(start),
    .n_pulses_i(n_pulses), .delay_i(delay), .busy_o(busy17), .done_o(done17), .miss_o(miss17),
    .acc_data_o(data17), .acc_valid_o(valid17), .acc_last_o(last17), .acc_ready_i(ready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample pattern per kind; j = gate clock index, b = 0 for x0, 1 for x0z.
  function automatic int samp(input int kind, input int j, input int b);
    case (kind)
      0:       return 2 * j + b;
      1:       return (b != 0) ? 50 : -100;
      2:       return 32767;
      default: return (b != 0) ? 1000 + j : -(j + 1);
    endcase
  endfunction

  task automatic do_start(input int n, input int d);
    @(negedge clk);
    n_pulses = 8'(n);
    delay    = 16'(d);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic pulse(input int d, input int kind, input int miss_at, input int rst_at);
    @(negedge clk);
    trig = 1'b1;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      trig = 1'b0;
    end
    for (int j = 0; j < GL; j++) begin
      @(negedge clk);
      trig = (j == miss_at);
      x0   = 16'(samp(kind, j, 0));
      x0z  = 16'(samp(kind, j, 1));
      if (j == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        trig  = 1'b0;
        return;
      end
    end
  endtask

  task automatic read_all(input int kind, input int n, input bit rnd, input bit c17);
    int idx = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [31:0] hd = '0;
    logic [31:0] e;
    while (idx < 2 * GL && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_data", data, hd);
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold  = valid && !ready;
      hd    = data;
      if (valid && ready) begin
        e = 32'(n * samp(kind, idx / 2, idx % 2));
        chk("data", data, e);
        chk("last", 32'(last), 32'(idx == 2 * GL - 1));
        if (c17) begin
          chk("valid17", 32'(valid17), 32'd1);
          chk("data17", 32'(data17), 32'(e[16:0]));
          chk("last17", 32'(last17), 32'(idx == 2 * GL - 1));
        end
        idx++;
      end
    end
    chk("words_delivered", 32'(idx), 32'(2 * GL));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("valid_after_done", 32'(valid), 32'd0);
    if (c17) chk("done17", 32'(done17), 32'd1);
    @(negedge clk);
    chk("done_one_clock", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; trig = 1'b0; start = 1'b0; ready = 1'b0;
    x0 = '0; x0z = '0; n_pulses = '0; delay = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_data", data, 32'd0);
    rst_n = 1'b1;

    // Ramp, n=1, delay 0: words 0..15 in order.
    do_start(1, 0);
    chk("miss_clear", 32'(miss), 32'd0);
    pulse(0, 0, -1, -1);
    read_all(0, 1, 1'b0, 1'b0);

    // n=4, delay=3, constant negative/positive samples.
    do_start(4, 3);
    repeat (4) pulse(3, 1, -1, -1);
    read_all(1, 4, 1'b0, 1'b0);

    // n=3 full-scale: wraps in the 17-bit instance.
    do_start(3, 0);
    chk("miss17_clear", 32'(miss17), 32'd0);
    chk("busy17", 32'(busy17), 32'd1);
    repeat (3) pulse(0, 2, -1, -1);
    read_all(2, 3, 1'b0, 1'b1);

    // Second trigger edge during ACCUM: sticky miss, result unaffected.
    do_start(1, 0);
    pulse(0, 0, 4, -1);
    chk("miss_set", 32'(miss), 32'd1);
    read_all(0, 1, 1'b0, 1'b0);
    chk("miss_sticky", 32'(miss), 32'd1);

    // n=0 treated as 1; random backpressure during readout; start clears miss.
    do_start(0, 0);
    chk("miss_cleared_by_start", 32'(miss), 32'd0);
    pulse(0, 3, -1, -1);
    read_all(3, 1, 1'b1, 1'b0);

    // Reset during pulse 2 of 4, then a clean single-pulse run.
    do_start(4, 0);
    pulse(0, 0, -1, -1);
    pulse(0, 0, -1, 3);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    do_start(1, 0);
    pulse(0, 1, -1, -1);
    read_all(1, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
